alu_result_serializer: RTL and testbench
========================================

Name: alu_result_serializer

Overview:
- Consumer end of the ALU result interface. Captures each registered 2*DATA_WIDTH-bit ALU result on its valid strobe and splits it into DATA_WIDTH-bit frames.
- Hands the frames, low byte first, to the UART transmitter through a valid/busy handshake.
- Holds one pending result while a transfer is in progress and flags any result lost to overflow.
- Drives a BUSY indication back to the system controller so it can stall new ALU commands.

Parameters:
- DATA_WIDTH, 8, width of each ALU operand and of each transmitted frame. The result width is 2*DATA_WIDTH.

Ports:
- CLK  input  1  system clock, all logic on rising edge
- RST  input  1  synchronous, active-high reset
- ALU_OUT  input  2*DATA_WIDTH  registered ALU result
- OUT_VALID  input  1  one-cycle strobe; ALU_OUT is valid this cycle
- TX_BUSY  input  1  UART transmitter busy; high while a frame is being shifted out
- TX_P_DATA  output  DATA_WIDTH  parallel frame to transmitter
- TX_D_VLD  output  1  one-cycle request; TX_P_DATA is valid
- BUSY  output  1  high while a transfer is active or the pending slot is full
- DROP_ERR  output  1  one-cycle pulse when a result is discarded

Behaviour:
- Reset (RST=1 at a clock edge):
  - TX_P_DATA=0, TX_D_VLD=0, BUSY=0, DROP_ERR=0.
  - FSM goes to IDLE. Active and pending registers are cleared and marked empty.
  - Reset mid-transfer abandons the transfer with no further TX_D_VLD.
- Storage:
  - Active register (2*DATA_WIDTH) holds the result being sent.
  - Pending register (2*DATA_WIDTH) has a valid flag.
- FSM states: IDLE, LO_REQ, LO_WAIT_BUSY, LO_WAIT_DONE, HI_REQ, HI_WAIT_BUSY, HI_WAIT_DONE.
- IDLE:
  - On OUT_VALID=1, load ALU_OUT into active and go to LO_REQ.
  - Else, if pending is valid, move pending to active, clear the pending flag, and go to LO_REQ.
- LO_REQ:
  - If TX_BUSY=0: TX_P_DATA=active[DATA_WIDTH-1:0], TX_D_VLD=1 for exactly one cycle, go to LO_WAIT_BUSY.
  - Else hold in LO_REQ.
- LO_WAIT_BUSY: wait for TX_BUSY=1, then go to LO_WAIT_DONE. The transmitter raises BUSY within 2 cycles of accepting a request.
- LO_WAIT_DONE: wait for TX_BUSY=0, then go to HI_REQ.
- HI_REQ, HI_WAIT_BUSY, HI_WAIT_DONE: same sequence as the LO states, using active[2*DATA_WIDTH-1:DATA_WIDTH].
- Leaving HI_WAIT_DONE:
  - If pending is valid, go to LO_REQ with pending moved to active. There is no IDLE bubble.
  - Else go to IDLE.
- TX_P_DATA holds its last value when TX_D_VLD=0. It changes only in the cycle TX_D_VLD is asserted.
- OUT_VALID while not IDLE:
  - If pending is empty, capture into pending.
  - If pending is full, keep the old pending value, discard the new result, and pulse DROP_ERR for one cycle.
- Simultaneous events:
  - OUT_VALID in the same cycle HI_WAIT_DONE completes with pending empty: the new result goes directly to active and the FSM enters LO_REQ.
  - OUT_VALID in the same cycle HI_WAIT_DONE completes with pending full: pending moves to active, the new result goes to pending, and nothing is dropped.
- BUSY = (state != IDLE) OR pending valid. BUSY is a registered output.
- Latency: OUT_VALID in IDLE at cycle N with TX_BUSY=0 gives TX_D_VLD for the low byte at cycle N+2.
- No arithmetic is performed. The low byte is always transmitted first, including for results whose upper half is zero.

Decomposition:
- Shared package (sys_pkg):
  - DATA_WIDTH default.
  - FSM state encoding localparams (3-bit binary).
  - Constant LSB_FIRST = 1, documented for the host-side decoder.
- No sub-module required. The pending slot stays inline; it is not worth a generic FIFO instance.

Test Plan:
1. Reset then a single result: RST for 2 cycles; ALU_OUT=16'h12C4 with one OUT_VALID pulse; TX model asserts TX_BUSY 1 cycle after each request and holds it 10 cycles. Required: TX_D_VLD with 8'hC4, then later with 8'h12; BUSY high from the cycle after OUT_VALID until the cycle after the second TX_BUSY fall; no DROP_ERR.
2. Back-to-back results: 16'h0003 then 16'hFF00 four cycles later. Required: frames 03, 00, 00, FF in order; the second result starts with no IDLE cycle between them.
3. Overflow: three results 16'h0001, 16'h0002, 16'h0003 on consecutive cycles. Required: DROP_ERR pulses once, on the third; frames 01, 00, 02, 00 only.
4. TX stall: TX_BUSY held high for 50 cycles before the first request. Required: FSM stays in LO_REQ with TX_D_VLD=0; the request issues the cycle after TX_BUSY falls.
5. Reset mid-transfer: RST asserted during HI_WAIT_DONE with pending full. Required: all outputs 0 the next cycle; no further TX_D_VLD; the next result after reset is transmitted normally.
6. Simultaneous completion and new result: OUT_VALID coincides with the HI_WAIT_DONE exit while pending is full (16'hAAAA, new 16'h5555). Required: 16'hAAAA is sent, then 16'h5555; DROP_ERR stays 0.

Source files
------------

// File: rtl/sys_pkg.sv
// Shared definitions for the ALU result path: default widths, serializer
// state encoding and the frame ordering contract with the host decoder.
package sys_pkg;

   localparam int DATA_WIDTH_DEF = 8;

   // Host-side decoder reassembles results assuming the low frame arrives first.
   localparam bit LSB_FIRST = 1'b1;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      LO_REQ       = 3'd1,
      LO_WAIT_BUSY = 3'd2,
      LO_WAIT_DONE = 3'd3,
      HI_REQ       = 3'd4,
      HI_WAIT_BUSY = 3'd5,
      HI_WAIT_DONE = 3'd6
   } state_t;

endpackage

// File: rtl/alu_result_serializer.sv
// Splits each 2*DATA_WIDTH ALU result into two frames (low first) for the UART
// transmitter, with a one-deep pending slot and drop reporting on overflow.
module alu_result_serializer
   import sys_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
   input  logic                    OUT_VALID,
   input  logic                    TX_BUSY,
   output logic [DATA_WIDTH-1:0]   TX_P_DATA,
   output logic                    TX_D_VLD,
   output logic                    BUSY,
   output logic                    DROP_ERR
);

   localparam int RW = 2 * DATA_WIDTH;

   state_t        state, state_nx;
   logic [RW-1:0] active, active_nx;
   logic [RW-1:0] pend, pend_nx;
   logic          pend_vld, pend_vld_nx;
   logic          send, drop, absorbed;

   always_comb begin
      state_nx    = state;
      active_nx   = active;
      pend_nx     = pend;
      pend_vld_nx = pend_vld;
      send        = 1'b0;
      drop        = 1'b0;
      absorbed    = 1'b0;

      case (state)
         IDLE: begin
            if (OUT_VALID) begin
               active_nx = ALU_OUT;
               absorbed  = 1'b1;
               state_nx  = LO_REQ;
            end else if (pend_vld) begin
               active_nx   = pend;
               pend_vld_nx = 1'b0;
               state_nx    = LO_REQ;
            end
         end
         LO_REQ: begin
            if (!TX_BUSY) begin
               send     = 1'b1;
               state_nx = LO_WAIT_BUSY;
            end
         end
         LO_WAIT_BUSY: if (TX_BUSY)  state_nx = LO_WAIT_DONE;
         LO_WAIT_DONE: if (!TX_BUSY) state_nx = HI_REQ;
         HI_REQ: begin
            if (!TX_BUSY) begin
               send     = 1'b1;
               state_nx = HI_WAIT_BUSY;
            end
         end
         HI_WAIT_BUSY: if (TX_BUSY)  state_nx = HI_WAIT_DONE;
         HI_WAIT_DONE: begin
            if (!TX_BUSY) begin
               // A result arriving on the completion edge is never dropped:
               // the slot it would collide with is being freed this cycle.
               absorbed = 1'b1;
               if (pend_vld) begin
                  active_nx = pend;
                  state_nx  = LO_REQ;
                  if (OUT_VALID) pend_nx = ALU_OUT;
                  else           pend_vld_nx = 1'b0;
               end else if (OUT_VALID) begin
                  active_nx = ALU_OUT;
                  state_nx  = LO_REQ;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase

      if (OUT_VALID && !absorbed) begin
         if (!pend_vld) begin
            pend_nx     = ALU_OUT;
            pend_vld_nx = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         active    <= '0;
         pend      <= '0;
         pend_vld  <= 1'b0;
         TX_P_DATA <= '0;
         TX_D_VLD  <= 1'b0;
         BUSY      <= 1'b0;
         DROP_ERR  <= 1'b0;
      end else begin
         state    <= state_nx;
         active   <= active_nx;
         pend     <= pend_nx;
         pend_vld <= pend_vld_nx;
         TX_D_VLD <= send;
         if (send)
            TX_P_DATA <= (state == HI_REQ) ? active[RW-1:DATA_WIDTH] : active[DATA_WIDTH-1:0];
         BUSY     <= (state_nx != IDLE) || pend_vld_nx;
         DROP_ERR <= drop;
      end
   end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Randomized and directed bench for alu_result_serializer against a result-level
// occupancy model driven by a behavioural UART transmitter.
module tb_alu_result_serializer;

   localparam int DW = 8;

   logic          CLK = 1'b0;
   logic          RST;
   logic [2*DW-1:0] ALU_OUT;
   logic          OUT_VALID;
   logic          TX_BUSY;
   logic [DW-1:0] TX_P_DATA;
   logic          TX_D_VLD;
   logic          BUSY;
   logic          DROP_ERR;

   always #5 CLK = ~CLK;

   alu_result_serializer #(.DATA_WIDTH(DW)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .ALU_OUT   (ALU_OUT),
      .OUT_VALID (OUT_VALID),
      .TX_BUSY   (TX_BUSY),
      .TX_P_DATA (TX_P_DATA),
      .TX_D_VLD  (TX_D_VLD),
      .BUSY      (BUSY),
      .DROP_ERR  (DROP_ERR)
   );

   int checks = 0;
   int errors = 0;

   // Model: number of results held (active + pending) and expected frame order.
   int        occ = 0;
   logic [7:0] fq[$];
   logic [7:0] last_frame = '0;
   bit        exp_busy = 0, exp_drop = 0, armed = 0;
   bit        hi_wait = 0, hi_seen = 0, prev_busy = 0, rand_hold = 0;
   int        busy_cnt = 0, cyc_n = 0, frames = 0, drops = 0;
   int        first_req_cyc = -1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc_n);
      end
   endtask

   task automatic step(input bit ov, input logic [15:0] d, input bit rst_in, input int stall);
      bit req, tb, comp;
      cyc_n++;
      OUT_VALID = ov;
      ALU_OUT   = d;
      RST       = rst_in;
      TX_BUSY   = (busy_cnt > 0);
      tb        = TX_BUSY;
      @(negedge CLK);
      req = 0;
      if (armed) begin
         check_eq("busy", 32'(BUSY), 32'(exp_busy));
         check_eq("drop_err", 32'(DROP_ERR), 32'(exp_drop));
         if (TX_D_VLD === 1'b1) begin
            req = 1;
            if (first_req_cyc < 0) first_req_cyc = cyc_n;
            check_eq("req_while_tx_busy", 32'(prev_busy), 32'd0);
            if (fq.size() == 0) check_eq("spurious_vld", 32'(TX_D_VLD), 32'd0);
            else                check_eq("frame", 32'(TX_P_DATA), 32'(fq.pop_front()));
            last_frame = TX_P_DATA;
            frames++;
            if (frames % 2 == 0) hi_wait = 1;
         end else begin
            check_eq("vld_idle", 32'(TX_D_VLD), 32'd0);
            check_eq("data_hold", 32'(TX_P_DATA), 32'(last_frame));
         end
      end
      prev_busy = tb;
      @(posedge CLK);
      if (rst_in) begin
         occ = 0; fq.delete(); last_frame = '0; exp_busy = 0; exp_drop = 0;
         hi_wait = 0; hi_seen = 0; frames = 0; armed = 1;
      end else begin
         comp = hi_wait && hi_seen && !tb;
         if (comp) begin
            occ--; hi_wait = 0; hi_seen = 0;
         end
         if (hi_wait && tb) hi_seen = 1;
         exp_drop = 0;
         if (ov) begin
            if (occ < 2) begin
               occ++;
               fq.push_back(d[7:0]);
               fq.push_back(d[15:8]);
            end else begin
               exp_drop = 1;
               drops++;
            end
         end
         exp_busy = (occ > 0);
      end
      if (busy_cnt > 0) busy_cnt--;
      if (req) busy_cnt = rand_hold ? int'($urandom_range(1, 12)) : 10;
      else if (stall > 0 && busy_cnt == 0) busy_cnt = stall;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 16'h0, 0, 0);
   endtask

   task automatic drain();
      int n = 0;
      while (!(occ == 0 && busy_cnt == 0) && n < 3000) begin
         step(0, 16'h0, 0, 0);
         n++;
      end
      check_eq("drain_timeout", 32'(n < 3000), 32'd1);
      idle(2);
      check_eq("frames_left", 32'(fq.size()), 32'd0);
   endtask

   initial begin
      int ovc, s, d0, n;
      RST = 1'b1; OUT_VALID = 1'b0; ALU_OUT = '0; TX_BUSY = 1'b0;
      step(0, 16'h0, 1, 0);
      step(0, 16'h0, 1, 0);
      idle(2);

      // Single result, plus request latency from the strobe.
      first_req_cyc = -1;
      ovc = cyc_n + 1;
      step(1, 16'h12C4, 0, 0);
      drain();
      check_eq("latency", 32'(first_req_cyc - ovc), 32'd2);

      // Back-to-back results four cycles apart.
      step(1, 16'h0003, 0, 0);
      idle(3);
      step(1, 16'hFF00, 0, 0);
      drain();

      // Overflow: third consecutive result is dropped.
      d0 = drops;
      step(1, 16'h0001, 0, 0);
      step(1, 16'h0002, 0, 0);
      step(1, 16'h0003, 0, 0);
      drain();
      check_eq("overflow_drops", 32'(drops - d0), 32'd1);

      // Transmitter stalled for 50 cycles before the first request.
      first_req_cyc = -1;
      s = cyc_n + 1;
      step(0, 16'h0, 0, 50);
      step(1, 16'hA55A, 0, 0);
      drain();
      check_eq("stall_release", 32'(first_req_cyc), 32'(s + 52));

      // Reset while in HI_WAIT_DONE with the pending slot full.
      step(1, 16'h3C5A, 0, 0);
      idle(3);
      step(1, 16'h7E81, 0, 0);
      n = 0;
      while (!(hi_wait && hi_seen) && n < 200) begin
         step(0, 16'h0, 0, 0);
         n++;
      end
      check_eq("reach_hi_wait_done", 32'(n < 200), 32'd1);
      idle(2);
      step(0, 16'h0, 1, 0);
      idle(15);
      step(1, 16'hBEEF, 0, 0);
      drain();

      // Completion and new result on the same edge, pending full.
      d0 = drops;
      step(1, 16'h1234, 0, 0);
      idle(2);
      step(1, 16'hAAAA, 0, 0);
      n = 0;
      while (!(hi_wait && hi_seen && busy_cnt == 0) && n < 200) begin
         step(0, 16'h0, 0, 0);
         n++;
      end
      check_eq("reach_completion", 32'(n < 200), 32'd1);
      step(1, 16'h5555, 0, 0);
      drain();
      check_eq("simul_no_drop", 32'(drops - d0), 32'd0);

      // Randomized traffic with variable transmitter timing and stalls.
      rand_hold = 1;
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 3) == 0), 16'($urandom),
              0, ($urandom_range(0, 30) == 0) ? int'($urandom_range(2, 20)) : 0);
      end
      drain();
      rand_hold = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
